ibufds_deser: RTL and testbench

Parametrised multi-channel differential input buffer model with an integrated serial-to-parallel deserializer, word alignment (bitslip) and differential-fault detection, written for Verilator simulation. It sits at the FPGA pad boundary of source-synchronous receive paths. It resolves each I/IB pair to a single-ended bit, exposes that bit registered on O, and assembles DATA_WIDTH-bit words per channel on a shared strobe.

---
 rtl/ibufds_deser.sv | 170 +++++++++++++++++
 tb/tb_ibufds_deser.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibufds_deser.sv
// ibufds_deser: multi-channel differential input buffer model with a shared-strobe
// serial-to-parallel deserializer, bitslip word alignment and sticky
// differential-fault flags. The per-channel datapath is in ibufds_deser_lane.
// The top level holds the shared bit counter and the word register.

// Per-channel slice: resolves the I/IB pair, registers the resolved bit,
// shifts it into the word assembly register and tracks the sticky fault flag.
module ibufds_deser_lane #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit DIFF_CHECK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  i_i,
    input  logic                  ib_i,
    input  logic                  clr_err_i,
    output logic                  o_o,
    output logic [DATA_WIDTH-1:0] shift_o,
    output logic                  err_o
);
    logic                  fault;
    logic                  res;
    logic                  o_q, o_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;

    // Resolve the pair. An equal pair is invalid when checking is on; the
    // previous resolved bit (o_q doubles as the held bit) stands in for it.
    always_comb begin
        fault = DIFF_CHECK && (i_i == ib_i);
        res   = fault ? o_q : i_i;
        o_d   = res;
        err_d = (err_q & ~clr_err_i) | fault;
    end

    // Next shift value; shift_o exposes it so a completing word includes the
    // bit sampled on the same edge.
    always_comb begin
        sh_d = sh_q;
        if (ce_i) begin
            if (MSB_FIRST) sh_d = {sh_q[DATA_WIDTH-2:0], res};
            else           sh_d = {res, sh_q[DATA_WIDTH-1:1]};
        end
    end

    // Lane state: resolved/held bit, shift register and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_q   <= 1'b0;
            err_q <= 1'b0;
            sh_q  <= '0;
        end else begin
            o_q   <= o_d;
            err_q <= err_d;
            sh_q  <= sh_d;
        end
    end

    assign o_o     = o_q;
    assign shift_o = sh_d;
    assign err_o   = err_q;
endmodule

module ibufds_deser #(
    parameter int    CHANNELS   = 1,
    parameter int    DATA_WIDTH = 8,
    parameter string BIT_ORDER  = "MSB_FIRST",
    parameter string DIFF_CHECK = "TRUE",
    parameter string DIFF_TERM  = "FALSE",
    parameter string IOSTANDARD = "DEFAULT"
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           CE,
    input  logic [CHANNELS-1:0]            I,
    input  logic [CHANNELS-1:0]            IB,
    input  logic                           BITSLIP,
    input  logic                           CLR_ERR,
    output logic [CHANNELS-1:0]            O,
    output logic [CHANNELS*DATA_WIDTH-1:0] Q,
    output logic                           Q_VALID,
    output logic [CHANNELS-1:0]            DIFF_ERR
);
    localparam bit MSB_FIRST_L  = (BIT_ORDER == "MSB_FIRST");
    localparam bit DIFF_CHECK_L = (DIFF_CHECK == "TRUE");
    localparam int CW           = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    // Elaboration-time parameter sanity; DIFF_TERM and IOSTANDARD only need
    // to be legal values since they do not change behaviour.
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("ibufds_deser: CHANNELS must be 1..32");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 16) begin : g_bad_width
        $error("ibufds_deser: DATA_WIDTH must be 2..16");
    end
    if (BIT_ORDER != "MSB_FIRST" && BIT_ORDER != "LSB_FIRST") begin : g_bad_order
        $error("ibufds_deser: BIT_ORDER must be MSB_FIRST or LSB_FIRST");
    end
    if (DIFF_CHECK != "TRUE" && DIFF_CHECK != "FALSE") begin : g_bad_check
        $error("ibufds_deser: DIFF_CHECK must be TRUE or FALSE");
    end
    if (DIFF_TERM != "TRUE" && DIFF_TERM != "FALSE") begin : g_bad_term
        $error("ibufds_deser: DIFF_TERM must be TRUE or FALSE");
    end
    if (IOSTANDARD == "") begin : g_bad_iostd
        $error("ibufds_deser: IOSTANDARD must not be empty");
    end

    logic [CHANNELS-1:0][DATA_WIDTH-1:0] word;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                qv_q, qv_d;
    logic                                emit;

    // One lane per differential pair.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        ibufds_deser_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MSB_FIRST  (MSB_FIRST_L),
            .DIFF_CHECK (DIFF_CHECK_L)
        ) u_lane (
            .clk_i     (CLK),
            .rst_i     (RST),
            .ce_i      (CE),
            .i_i       (I[n]),
            .ib_i      (IB[n]),
            .clr_err_i (CLR_ERR),
            .o_o       (O[n]),
            .shift_o   (word[n]),
            .err_o     (DIFF_ERR[n])
        );
    end

    // Shared bit counter. BITSLIP freezes it for one enabled bit, pushing the
    // word boundary one bit later; a word is emitted only on a non-slip edge
    // that finds the counter at its last position.
    always_comb begin
        cnt_d = cnt_q;
        emit  = 1'b0;
        if (CE && !BITSLIP) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                emit  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        q_d  = emit ? word : q_q;
        qv_d = emit;
    end

    // Counter, word register and one-cycle valid strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            q_q   <= '0;
            qv_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
            qv_q  <= qv_d;
        end
    end

    assign Q       = q_q;
    assign Q_VALID = qv_q;
endmodule

// File: tb/tb_ibufds_deser.sv
// Bench for ibufds_deser: three instances (MSB/8/check, LSB/8/check,
// MSB/5/no-check) share the stimulus; a word-history reference model checks
// them every cycle, alongside a fault-flag vector table and directed sequences.
module tb_ibufds_deser;
    logic       clk = 1'b0;
    logic       rst, ce, bitslip, clr;
    logic [1:0] i, ib;

    logic [1:0]  o0, o1, o2, e0, e1, e2;
    logic [15:0] q0, q1;
    logic [9:0]  q2;
    logic        v0, v1, v2;

    always #5 clk = ~clk;

    ibufds_deser #(.CHANNELS(2), .DATA_WIDTH(8), .BIT_ORDER("MSB_FIRST"), .DIFF_CHECK("TRUE"),
                   .DIFF_TERM("FALSE"), .IOSTANDARD("DEFAULT")) u0 (
        .CLK(clk), .RST(rst), .CE(ce), .I(i), .IB(ib), .BITSLIP(bitslip), .CLR_ERR(clr),
        .O(o0), .Q(q0), .Q_VALID(v0), .DIFF_ERR(e0));
    ibufds_deser #(.CHANNELS(2), .DATA_WIDTH(8), .BIT_ORDER("LSB_FIRST"), .DIFF_CHECK("TRUE"),
                   .DIFF_TERM("TRUE"), .IOSTANDARD("LVDS")) u1 (
        .CLK(clk), .RST(rst), .CE(ce), .I(i), .IB(ib), .BITSLIP(bitslip), .CLR_ERR(clr),
        .O(o1), .Q(q1), .Q_VALID(v1), .DIFF_ERR(e1));
    ibufds_deser #(.CHANNELS(2), .DATA_WIDTH(5), .BIT_ORDER("MSB_FIRST"), .DIFF_CHECK("FALSE"),
                   .DIFF_TERM("FALSE"), .IOSTANDARD("DEFAULT")) u2 (
        .CLK(clk), .RST(rst), .CE(ce), .I(i), .IB(ib), .BITSLIP(bitslip), .CLR_ERR(clr),
        .O(o2), .Q(q2), .Q_VALID(v2), .DIFF_ERR(e2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: each channel keeps its full history of accepted bits;
    // a word is simply the last DW bits, ordered by BIT_ORDER.
    int          DWS [3] = '{8, 8, 5};
    bit          MSBS[3] = '{1'b1, 1'b0, 1'b1};
    bit          CHKS[3] = '{1'b1, 1'b1, 1'b0};
    int          mcnt[3];
    logic [1:0]  mo[3], merr[3];
    logic [31:0] mq[3];
    logic        mqv[3];
    logic [31:0] hist[3][2];

    function automatic logic [31:0] mword(input int k, input int n);
        logic [31:0] h, r;
        int dw;
        dw = DWS[k];
        h  = hist[k][n] & ((32'd1 << dw) - 32'd1);
        if (MSBS[k]) return h;
        r = '0;
        for (int j = 0; j < dw; j++) r[j] = h[dw-1-j];
        return r;
    endfunction

    task automatic model_edge();
        logic [1:0] newo;
        logic       res, fault;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mcnt[k] = 0; mo[k] = '0; merr[k] = '0; mq[k] = '0; mqv[k] = 1'b0;
                hist[k][0] = '0; hist[k][1] = '0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    fault      = CHKS[k] && (i[n] == ib[n]);
                    res        = fault ? mo[k][n] : i[n];
                    merr[k][n] = (merr[k][n] & ~clr) | fault;
                    newo[n]    = res;
                    if (ce) hist[k][n] = {hist[k][n][30:0], res};
                end
                mqv[k] = 1'b0;
                if (ce && !bitslip) begin
                    if (mcnt[k] == DWS[k] - 1) begin
                        mcnt[k] = 0;
                        mq[k]   = (mword(k, 1) << DWS[k]) | mword(k, 0);
                        mqv[k]  = 1'b1;
                    end else begin
                        mcnt[k] = mcnt[k] + 1;
                    end
                end
                mo[k] = newo;
            end
        end
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] o, input logic [31:0] q,
                            input logic [31:0] qv, input logic [31:0] err);
        chk($sformatf("u%0d.O", k),        o,   32'(mo[k]));
        chk($sformatf("u%0d.Q", k),        q,   mq[k]);
        chk($sformatf("u%0d.Q_VALID", k),  qv,  32'(mqv[k]));
        chk($sformatf("u%0d.DIFF_ERR", k), err, 32'(merr[k]));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp_inst(0, 32'(o0), 32'(q0), 32'(v0), 32'(e0));
        cmp_inst(1, 32'(o1), 32'(q1), 32'(v1), 32'(e1));
        cmp_inst(2, 32'(o2), 32'(q2), 32'(v2), 32'(e2));
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; bitslip = 1'b0; clr = 1'b0; i = 2'b01; ib = 2'b10;
        step();
        rst = 1'b0;
    endtask

    // Drive one MSB-first bit of each pattern with a valid pair.
    task automatic drive_bits(input logic [7:0] p0, input logic [7:0] p1, input int idx);
        i  = {p1[7-idx], p0[7-idx]};
        ib = ~i;
    endtask

    typedef struct {
        logic [1:0] i;
        logic [1:0] ib;
        logic       clr;
        logic [1:0] o;
        logic [1:0] err;
    } vec_t;
    vec_t tbl[7];

    initial begin
        logic [7:0] pat;
        rst = 1'b1; ce = 1'b0; bitslip = 1'b0; clr = 1'b0; i = '0; ib = '1;

        tbl[0] = '{i: 2'b01, ib: 2'b10, clr: 1'b0, o: 2'b01, err: 2'b00};
        tbl[1] = '{i: 2'b11, ib: 2'b10, clr: 1'b0, o: 2'b01, err: 2'b10};  // ch1 equal pair holds 0
        tbl[2] = '{i: 2'b00, ib: 2'b11, clr: 1'b0, o: 2'b00, err: 2'b10};  // sticky
        tbl[3] = '{i: 2'b10, ib: 2'b01, clr: 1'b1, o: 2'b10, err: 2'b00};  // cleared
        tbl[4] = '{i: 2'b10, ib: 2'b11, clr: 1'b1, o: 2'b10, err: 2'b10};  // set beats clear
        tbl[5] = '{i: 2'b00, ib: 2'b00, clr: 1'b1, o: 2'b10, err: 2'b11};  // both held
        tbl[6] = '{i: 2'b01, ib: 2'b10, clr: 1'b1, o: 2'b01, err: 2'b00};

        // Reset state.
        do_reset();
        chk("rst.O", 32'(o0), 0);
        chk("rst.Q", 32'(q0), 0);
        chk("rst.Q_VALID", 32'(v0), 0);
        chk("rst.DIFF_ERR", 32'(e0), 0);

        // Fault detection table, deserializer idle.
        foreach (tbl[r]) begin
            i = tbl[r].i; ib = tbl[r].ib; clr = tbl[r].clr;
            step();
            chk($sformatf("tbl%0d.O", r), 32'(o0), 32'(tbl[r].o));
            chk($sformatf("tbl%0d.DIFF_ERR", r), 32'(e0), 32'(tbl[r].err));
            chk($sformatf("tbl%0d.O_nocheck", r), 32'(o2), 32'(tbl[r].i));
        end
        clr = 1'b0;

        // Two-channel word, O latency and single-cycle strobe.
        do_reset();
        ce = 1'b1;
        for (int t = 0; t < 8; t++) begin
            drive_bits(8'hA5, 8'h3C, t);
            step();
            chk("A.O", 32'(o0), 32'(i));
            chk("A.Q_VALID", 32'(v0), 32'(t == 7));
        end
        chk("A.Q_msb", 32'(q0), 32'h3CA5);
        chk("A.Q_lsb", 32'(q1), 32'h3CA5);
        ce = 1'b0;
        step();
        chk("A.Q_VALID_drop", 32'(v0), 0);
        chk("A.Q_hold", 32'(q0), 32'h3CA5);

        // Single bitslip stretches one period to 9 and realigns to 0x4B.
        do_reset();
        ce = 1'b1;
        for (int s = 1; s <= 40; s++) begin
            drive_bits(8'hA5, 8'hA5, (s - 1) % 8);
            bitslip = (s == 20);
            step();
            chk($sformatf("B.Q_VALID@%0d", s), 32'(v0),
                32'(s == 8 || s == 16 || s == 25 || s == 33));
            if (s == 25 || s == 33) chk("B.Q", 32'(q0[7:0]), 32'h4B);
        end
        bitslip = 1'b0;

        // CE toggling: 8 enabled bits over 16 clocks.
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            ce = (c % 2 == 1);
            drive_bits(8'hA5, 8'hA5, (c - 1) / 2);
            step();
            chk($sformatf("C.Q_VALID@%0d", c), 32'(v0), 32'(c == 15));
            chk($sformatf("C.Q@%0d", c), 32'(q0[7:0]), (c >= 15) ? 32'hA5 : 32'h0);
        end

        // Reset mid-word discards the partial word and the fault flag.
        do_reset();
        ce = 1'b1;
        for (int t = 0; t < 8; t++) begin drive_bits(8'h3C, 8'h3C, t); step(); end
        chk("D.Q_pre", 32'(q0), 32'h3C3C);
        for (int t = 0; t < 5; t++) begin
            drive_bits(8'hFF, 8'hFF, t);
            if (t == 2) ib[1] = i[1];
            step();
        end
        chk("D.err_pre", 32'(e0), 32'h2);
        rst = 1'b1;
        step();
        chk("D.rst_O", 32'(o0), 0);
        chk("D.rst_Q", 32'(q0), 0);
        chk("D.rst_ERR", 32'(e0), 0);
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            drive_bits(8'h5A, 8'h5A, t);
            step();
            chk("D.Q_VALID", 32'(v0), 32'(t == 7));
        end
        chk("D.Q", 32'(q0[7:0]), 32'h5A);

        // Bit order on a non-palindromic stream.
        do_reset();
        ce = 1'b1;
        for (int t = 0; t < 8; t++) begin drive_bits(8'h12, 8'hC4, t); step(); end
        chk("E.Q_msb", 32'(q0), 32'hC412);
        chk("E.Q_lsb", 32'(q1), 32'h2348);

        // Random traffic against the model.
        pat = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            ce      = ($urandom_range(0, 3) != 0);
            bitslip = ($urandom_range(0, 9) == 0);
            clr     = ($urandom_range(0, 9) == 0);
            i       = 2'($urandom);
            ib      = ~i;
            if ($urandom_range(0, 7) == 0) ib[$urandom_range(0, 1)] = 1'($urandom);
            pat     = pat + 8'(i);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
